// File: rtl/maze_pkg.sv
// Shared definitions for maze sprites (player and ghost movers).
// Contents: one-hot direction constants ({down,right,up,left}, bit0 = left),
// the mover state enum, a direction reversal helper and a one-hot test.
package maze_pkg;

    localparam logic [3:0] DirNone  = 4'b0000;
    localparam logic [3:0] DirLeft  = 4'b0001;
    localparam logic [3:0] DirUp    = 4'b0010;
    localparam logic [3:0] DirRight = 4'b0100;
    localparam logic [3:0] DirDown  = 4'b1000;

    typedef enum logic [2:0] {
        StIni    = 3'd0,
        StRun    = 3'd1,
        StLookup = 3'd2,
        StDecide = 3'd3,
        StWin    = 3'd4,
        StLose   = 3'd5
    } state_e;

    // Opposite direction: left<->right, up<->down. Zero maps to zero.
    function automatic logic [3:0] reverse(input logic [3:0] d);
        return {d[1], d[0], d[3], d[2]};
    endfunction

    function automatic logic is_one_hot(input logic [3:0] d);
        return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/sprite_fill.sv
// Sprite raster test: asserts fill when the raster position lies inside the
// (2*HALF+1)-pixel square centred on the sprite, and drives rgb accordingly.
// Ports: pos_x_i/pos_y_i sprite centre, h_count_i/v_count_i raster position,
//        bright_i visible-area flag, fill_o inside-sprite flag, rgb_o colour.
module sprite_fill
    import maze_pkg::*;
#(
    parameter int unsigned X_W   = 10,
    parameter int unsigned HALF  = 2,
    parameter logic [11:0] COLOR = 12'hFF0
) (
    input  logic [X_W-1:0] pos_x_i,
    input  logic [X_W-1:0] pos_y_i,
    input  logic [X_W-1:0] h_count_i,
    input  logic [X_W-1:0] v_count_i,
    input  logic           bright_i,
    output logic           fill_o,
    output logic [11:0]    rgb_o
);

    logic [X_W-1:0] dx;
    logic [X_W-1:0] dy;

    always_comb begin
        // Absolute distances without signed arithmetic.
        dx = (h_count_i >= pos_x_i) ? (h_count_i - pos_x_i) : (pos_x_i - h_count_i);
        dy = (v_count_i >= pos_y_i) ? (v_count_i - pos_y_i) : (pos_y_i - v_count_i);
        fill_o = (dx <= X_W'(HALF)) && (dy <= X_W'(HALF));
        rgb_o = 12'h000;
        if (bright_i && fill_o) begin
            rgb_o = COLOR;
        end
    end

endmodule

// File: rtl/maze_mover.sv
// Maze sprite mover. On each move_tick the sprite reads the map cell under
// it (one-cycle latency), picks a direction from the pending request and the
// open exits, then steps SPEED pixels, wrapping horizontally in the tunnel.
// Ports: clk/reset_n clock and async active-low reset; start/ack game
//        control; win/lose game outcome; move_tick step strobe; dir_req
//        one-hot request; hCount/vCount/bright raster; map_rd/map_x/map_y/
//        map_data map read port; pos_x/pos_y/dir/moving sprite status;
//        fill/rgb pixel output; state encoded FSM state.
module maze_mover
    import maze_pkg::*;
#(
    parameter int unsigned X_W     = 10,
    parameter int unsigned SPEED   = 5,
    parameter int unsigned HALF    = 2,
    parameter int unsigned X_INI   = 300,
    parameter int unsigned Y_INI   = 300,
    parameter int unsigned XOFFSET = 24,
    parameter int unsigned YOFFSET = 130,
    parameter int unsigned X_MIN   = 0,
    parameter int unsigned X_MAX   = 635,
    parameter logic [11:0] COLOR   = 12'hFF0
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic           ack,
    input  logic           win,
    input  logic           lose,
    input  logic           move_tick,
    input  logic           bright,
    input  logic [3:0]     dir_req,
    input  logic [X_W-1:0] hCount,
    input  logic [X_W-1:0] vCount,
    output logic           map_rd,
    output logic [X_W-1:0] map_x,
    output logic [X_W-1:0] map_y,
    input  logic [3:0]     map_data,
    output logic [X_W-1:0] pos_x,
    output logic [X_W-1:0] pos_y,
    output logic [3:0]     dir,
    output logic           moving,
    output logic           fill,
    output logic [11:0]    rgb,
    output logic [2:0]     state
);

    state_e         state_q, state_d;
    logic [X_W-1:0] pos_x_q, pos_x_d;
    logic [X_W-1:0] pos_y_q, pos_y_d;
    logic [3:0]     dir_q, dir_d;
    logic [3:0]     pending_q, pending_d;
    logic           map_rd_q, map_rd_d;
    logic [X_W-1:0] map_x_q, map_x_d;
    logic [X_W-1:0] map_y_q, map_y_d;
    logic [3:0]     new_dir;
    logic           active;

    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        dir_d     = dir_q;
        pending_d = pending_q;
        map_rd_d  = 1'b0;
        map_x_d   = map_x_q;
        map_y_d   = map_y_q;
        new_dir   = dir_q;
        active    = (state_q == StRun) || (state_q == StLookup) || (state_q == StDecide);

        unique case (state_q)
            StIni: begin
                pos_x_d   = X_W'(X_INI);
                pos_y_d   = X_W'(Y_INI);
                dir_d     = DirNone;
                pending_d = DirNone;
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (move_tick) begin
                    state_d  = StLookup;
                    map_rd_d = 1'b1;
                    map_x_d  = pos_x_q + X_W'(XOFFSET);
                    map_y_d  = pos_y_q + X_W'(YOFFSET);
                end
            end
            StLookup: begin
                // map_data becomes valid during DECIDE.
                state_d = StDecide;
            end
            StDecide: begin
                state_d = StRun;
                if (map_data == 4'b0000) begin
                    // Corridor: only an about-turn is allowed.
                    if (pending_q == reverse(dir_q)) begin
                        new_dir   = pending_q;
                        pending_d = DirNone;
                    end
                end else if ((pending_q & map_data) != 4'b0000) begin
                    new_dir   = pending_q;
                    pending_d = DirNone;
                end else if ((dir_q & map_data) == 4'b0000) begin
                    new_dir = DirNone;
                end
                dir_d = new_dir;
                case (new_dir)
                    DirLeft: begin
                        pos_x_d = (pos_x_q == X_W'(X_MIN)) ? X_W'(X_MAX)
                                                           : pos_x_q - X_W'(SPEED);
                    end
                    DirRight: begin
                        pos_x_d = (pos_x_q == X_W'(X_MAX)) ? X_W'(X_MIN)
                                                           : pos_x_q + X_W'(SPEED);
                    end
                    DirUp:   pos_y_d = pos_y_q - X_W'(SPEED);
                    DirDown: pos_y_d = pos_y_q + X_W'(SPEED);
                    default: ;
                endcase
            end
            StWin, StLose: begin
                dir_d = DirNone;
                if (ack) begin
                    state_d   = StIni;
                    pos_x_d   = X_W'(X_INI);
                    pos_y_d   = X_W'(Y_INI);
                    pending_d = DirNone;
                end
            end
            default: state_d = StIni;
        endcase

        // Game outcome overrides everything and abandons any step in flight.
        if (active && (lose || win)) begin
            state_d   = lose ? StLose : StWin;
            pos_x_d   = pos_x_q;
            pos_y_d   = pos_y_q;
            dir_d     = DirNone;
            pending_d = pending_q;
            map_rd_d  = 1'b0;
        end

        // Latest one-hot request wins, including over a consume in DECIDE.
        if (active && is_one_hot(dir_req)) begin
            pending_d = dir_req;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIni;
            pos_x_q   <= X_W'(X_INI);
            pos_y_q   <= X_W'(Y_INI);
            dir_q     <= DirNone;
            pending_q <= DirNone;
            map_rd_q  <= 1'b0;
            map_x_q   <= '0;
            map_y_q   <= '0;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            map_rd_q  <= map_rd_d;
            map_x_q   <= map_x_d;
            map_y_q   <= map_y_d;
        end
    end

    assign state  = state_q;
    assign pos_x  = pos_x_q;
    assign pos_y  = pos_y_q;
    assign dir    = dir_q;
    assign moving = (dir_q != DirNone);
    assign map_rd = map_rd_q;
    assign map_x  = map_x_q;
    assign map_y  = map_y_q;

    sprite_fill #(
        .X_W   (X_W),
        .HALF  (HALF),
        .COLOR (COLOR)
    ) u_sprite_fill (
        .pos_x_i   (pos_x_q),
        .pos_y_i   (pos_y_q),
        .h_count_i (hCount),
        .v_count_i (vCount),
        .bright_i  (bright),
        .fill_o    (fill),
        .rgb_o     (rgb)
    );

endmodule

// File: doc/maze_mover.md
MAZE_MOVER -- requirements
Module: maze_mover

Interface
REQ-001 SHALL have parameter X_W, default 10, coordinate width.
REQ-002 SHALL have parameter SPEED, default 5, pixels per step.
REQ-003 SHALL have parameter HALF, default 2, sprite half-size.
REQ-004 SHALL have parameters X_INI/Y_INI, defaults 300/300, start position.
REQ-005 SHALL have parameters XOFFSET/YOFFSET, defaults 24/130, screen-to-map offset.
REQ-006 SHALL have parameters X_MIN/X_MAX, defaults 0/635, horizontal tunnel bounds.
REQ-007 SHALL have parameter COLOR, default 12'hFF0, fill colour.
REQ-008 Ports SHALL be: clk in 1, sole clock; reset_n in 1, asynchronous active-low reset.
REQ-009 Ports SHALL be: start, ack, win, lose, move_tick, bright, all in 1.
REQ-010 Ports SHALL be: dir_req in 4, one-hot {down,right,up,left}, bit0 = left.
REQ-011 Ports SHALL be: hCount, vCount in X_W, raster position.
REQ-012 Ports SHALL be: map_rd out 1; map_x, map_y out X_W; map_data in 4, same bit order as dir_req, valid one cycle after map_rd.
REQ-013 Ports SHALL be: pos_x, pos_y, dir (out 4), moving, fill, rgb (out 12), state (out 3).

Function
REQ-014 States SHALL be INI, RUN, LOOKUP, DECIDE, WIN, LOSE.
REQ-015 INI: pos <= (X_INI, Y_INI), dir <= 0, pending <= 0; start -> RUN.
REQ-016 RUN: move_tick -> LOOKUP.
REQ-017 LOOKUP (one cycle): map_rd = 1, map_x = pos_x+XOFFSET, map_y = pos_y+YOFFSET; then -> DECIDE.
REQ-018 map_rd SHALL be 0 in every other state.
REQ-019 DECIDE (one cycle) then -> RUN; pos and dir update at the end of DECIDE.
REQ-020 A dir_req that is one-hot SHALL be latched into pending in any state except INI/WIN/LOSE; zero or multi-hot requests are ignored; a newer one-hot request overwrites the old.
REQ-021 DECIDE, map_data == 0 (corridor): pending == reverse(dir) -> dir <= pending, pending cleared; else dir kept.
REQ-022 DECIDE, map_data != 0 (node): (pending & map_data) != 0 -> dir <= pending, pending cleared; else if (dir & map_data) == 0 -> dir <= 0; else dir kept.
REQ-023 DECIDE: with new dir != 0, pos SHALL step SPEED in that direction.
REQ-024 Left at pos_x == X_MIN SHALL wrap pos_x to X_MAX; right at X_MAX SHALL wrap to X_MIN.
REQ-025 Vertical steps SHALL not wrap; the map guarantees legality.
REQ-026 move_tick in LOOKUP/DECIDE SHALL be dropped (at most one step per tick).
REQ-027 In RUN/LOOKUP/DECIDE, lose -> LOSE, else win -> WIN, taking priority over all other transitions and aborting any step in flight.
REQ-028 WIN/LOSE: pos frozen, dir <= 0; ack -> INI.
REQ-029 moving SHALL be (dir != 0).
REQ-030 fill SHALL be |hCount-pos_x| <= HALF and |vCount-pos_y| <= HALF, combinational.
REQ-031 rgb SHALL be 0 when ~bright; COLOR when fill; else 0 (no latch).
REQ-032 state SHALL encode INI=0, RUN=1, LOOKUP=2, DECIDE=3, WIN=4, LOSE=5.

Reset
REQ-033 reset_n low SHALL asynchronously force: state INI, pos_x X_INI, pos_y Y_INI, dir 0, pending 0, map_rd 0.
REQ-034 Reset mid-LOOKUP/DECIDE SHALL discard the step; no partial pos update.

Structure
REQ-035 Direction one-hot constants, the reverse() function and the state enum SHALL live in shared package maze_pkg, reused by ghost blocks.
REQ-036 Sub-module sprite_fill SHALL compute fill/rgb from pos, hCount, vCount, bright.

Verification
REQ-037 Reset, start, no tick -> state RUN, pos (300,300), map_rd never 1.
REQ-038 map_data=4'b0101, dir_req=left, tick -> map_rd high one cycle at (324,430); after DECIDE dir=0001, pos_x=295.
REQ-039 Moving left, corridor map_data=0, dir_req=up, two ticks -> pos_x 295 then 290, pending kept; next tick with map_data=4'b0011 -> dir=0010, pos_y=295.
REQ-040 Moving left at pos_x=0, map_data=0, tick -> pos_x=635.
REQ-041 Moving right into node map_data=4'b1000, no request -> dir=0, moving=0, pos unchanged.
REQ-042 win and lose asserted together during DECIDE -> LOSE, pos unchanged; ack -> INI, pos (300,300).
